// File: rtl/data_unpacking_stream.sv
// Word-to-subword stream unpacker with valid/ready on both sides, LSB- or MSB-first order.
// Optional per-word subword count via the UNPACK_PARTIAL_EN macro (adds the in_nwords port).
module data_unpacking_stream #(
  parameter  int IN_DATA_WIDTH  = 32,
  parameter  int OUT_DATA_WIDTH = 8,
  parameter  int LSB_FIRST      = 1,
  localparam int R              = IN_DATA_WIDTH / OUT_DATA_WIDTH,
  localparam int CNT_W          = ($clog2(R + 1) < 1) ? 1 : $clog2(R + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [IN_DATA_WIDTH-1:0]  in_data,
  input  logic                      in_last,
`ifdef UNPACK_PARTIAL_EN
  input  logic [CNT_W-1:0]          in_nwords,
`endif
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [OUT_DATA_WIDTH-1:0] out_data,
  output logic                      out_last
);

  typedef enum logic {IDLE, UNPACK} state_t;

  localparam logic [CNT_W-1:0] R_C = CNT_W'(R);

  state_t                    state_q, state_d;
  logic [IN_DATA_WIDTH-1:0]  sreg_q, sreg_d;
  logic [CNT_W-1:0]          rem_q, rem_d;
  logic                      last_q, last_d;
  logic [OUT_DATA_WIDTH-1:0] data_q, data_d;

  logic                      rem_one, accept, xfer;
  logic [CNT_W-1:0]          n_load;
  logic [OUT_DATA_WIDTH-1:0] in_first, sreg_next_slice;
  logic [IN_DATA_WIDTH-1:0]  in_shifted, sreg_shifted;

  assign rem_one   = (rem_q == CNT_W'(1));
  assign out_valid = (state_q == UNPACK);
  assign out_data  = data_q;
  assign out_last  = last_q && rem_one;
  assign in_ready  = rst_n && ((state_q == IDLE) || (out_ready && rem_one));
  assign accept    = in_valid && in_ready;
  assign xfer      = out_valid && out_ready;

`ifdef UNPACK_PARTIAL_EN
  // Out-of-range counts fall back to a full word.
  assign n_load = ((in_nwords == '0) || (in_nwords > R_C)) ? R_C : in_nwords;
`else
  assign n_load = R_C;
`endif

  assign in_first        = (LSB_FIRST != 0) ? in_data[OUT_DATA_WIDTH-1:0]
                                            : in_data[IN_DATA_WIDTH-1:IN_DATA_WIDTH-OUT_DATA_WIDTH];
  assign in_shifted      = (LSB_FIRST != 0) ? (in_data >> OUT_DATA_WIDTH)
                                            : (in_data << OUT_DATA_WIDTH);
  assign sreg_next_slice = (LSB_FIRST != 0) ? sreg_q[OUT_DATA_WIDTH-1:0]
                                            : sreg_q[IN_DATA_WIDTH-1:IN_DATA_WIDTH-OUT_DATA_WIDTH];
  assign sreg_shifted    = (LSB_FIRST != 0) ? (sreg_q >> OUT_DATA_WIDTH)
                                            : (sreg_q << OUT_DATA_WIDTH);

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    rem_d   = rem_q;
    last_d  = last_q;
    data_d  = data_q;
    // An accept in UNPACK only happens on the final-subword transfer, so it takes priority.
    if (accept) begin
      data_d  = in_first;
      sreg_d  = in_shifted;
      rem_d   = n_load;
      last_d  = in_last;
      state_d = UNPACK;
    end else if (xfer) begin
      if (rem_one) begin
        rem_d   = '0;
        last_d  = 1'b0;
        state_d = IDLE;
      end else begin
        data_d = sreg_next_slice;
        sreg_d = sreg_shifted;
        rem_d  = rem_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      rem_q   <= '0;
      last_q  <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      rem_q   <= rem_d;
      last_q  <= last_d;
      data_q  <= data_d;
    end
  end

endmodule
